rpn_stack_master: RTL and testbench

//  Initiator-side controller for the 4-bit LIFO stack. Accepts a token stream
//  (operands/operators) over valid/ready. Drives the stack's Push/Pop/Data_In,

---
 rtl/rpn_stack_master.sv | 154 +++++++++++++++
 tb/tb_rpn_stack_master.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_master.sv
// rpn_stack_master: reverse-Polish evaluator driving an external LIFO stack over push/pop strobes.
// Tokens are accepted only in IDLE; every output comes straight from a register.
module rpn_stack_master #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8
) (
   input  logic                     Clk,
   input  logic                     RstN,
   input  logic                     Tok_Valid,
   input  logic                     Tok_Is_Op,
   input  logic [DATA_W-1:0]        Tok_Data,
   output logic                     Tok_Ready,
   output logic [DATA_W-1:0]        Stk_Data_In,
   output logic                     Stk_Push,
   output logic                     Stk_Pop,
   input  logic [DATA_W-1:0]        Stk_Data_Out,
   input  logic                     Stk_Full,
   input  logic                     Stk_Empty,
   output logic                     Res_Valid,
   output logic [DATA_W-1:0]        Res_Data,
   output logic                     Err,
   output logic [1:0]               Err_Code,
   output logic [$clog2(DEPTH):0]   Depth
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] MAX_D = CW'(DEPTH);
   typedef enum logic [2:0] {IDLE, PUSH, POP_B, POP_A, EXEC, PUSH_R, CAPT, CLR} state_t;
   state_t            r_state;
   logic              r_ready, r_push, r_pop, r_res_valid, r_err;
   logic [DATA_W-1:0] r_data_in, r_res_data, r_b;
   logic [1:0]        r_code;
   logic [2:0]        r_op;
   logic [CW-1:0]     r_depth;
   logic [DATA_W-1:0] w_alu;
   logic [2:0]        w_opc;
   assign w_opc = Tok_Data[2:0];
   // A is on Stk_Data_Out during EXEC, B was captured one cycle earlier
   always_comb
      w_alu = r_op == 3'd0 ? Stk_Data_Out + r_b :
              r_op == 3'd1 ? Stk_Data_Out - r_b :
              r_op == 3'd2 ? Stk_Data_Out & r_b :
              r_op == 3'd3 ? Stk_Data_Out | r_b : Stk_Data_Out ^ r_b;
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         r_state     <= IDLE;
         r_ready     <= 1'b1;
         r_push      <= 1'b0;
         r_pop       <= 1'b0;
         r_data_in   <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_err       <= 1'b0;
         r_code      <= 2'b00;
         r_depth     <= '0;
         r_b         <= '0;
         r_op        <= 3'd0;
      end else begin
         r_res_valid <= 1'b0;
         case (r_state)
            IDLE: if (Tok_Valid) begin
               if (!Tok_Is_Op) begin
                  if (r_depth == MAX_D || Stk_Full) begin
                     r_err  <= 1'b1;
                     r_code <= 2'b01;
                  end else begin
                     r_state   <= PUSH;
                     r_push    <= 1'b1;
                     r_data_in <= Tok_Data;
                     r_ready   <= 1'b0;
                  end
               end else if (w_opc == 3'd7) begin
                  r_err  <= 1'b1;
                  r_code <= 2'b11;
               end else if (w_opc == 3'd6) begin
                  if (r_depth == '0) begin
                     r_err  <= 1'b0;
                     r_code <= 2'b00;
                  end else begin
                     r_state <= CLR;
                     r_pop   <= 1'b1;
                     r_ready <= 1'b0;
                  end
               end else if (w_opc == 3'd5 ? (r_depth == '0 || Stk_Empty) : (r_depth < CW'(2))) begin
                  r_err  <= 1'b1;
                  r_code <= 2'b10;
               end else begin
                  r_op    <= w_opc;
                  r_state <= POP_B;
                  r_pop   <= 1'b1;
                  r_ready <= 1'b0;
               end
            end
            PUSH: begin
               r_push  <= 1'b0;
               r_depth <= r_depth + 1'b1;
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
            POP_B: begin
               r_pop   <= r_op != 3'd5;
               r_state <= r_op == 3'd5 ? CAPT : POP_A;
            end
            POP_A: begin
               r_b     <= Stk_Data_Out;
               r_pop   <= 1'b0;
               r_state <= EXEC;
            end
            EXEC: begin
               r_data_in <= w_alu;
               r_push    <= 1'b1;
               r_state   <= PUSH_R;
            end
            PUSH_R: begin
               r_push  <= 1'b0;
               r_depth <= r_depth - 1'b1;
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
            CAPT: begin
               r_res_data  <= Stk_Data_Out;
               r_res_valid <= 1'b1;
               r_depth     <= r_depth - 1'b1;
               r_state     <= IDLE;
               r_ready     <= 1'b1;
            end
            CLR: begin
               r_depth <= r_depth - 1'b1;
               if (r_depth == CW'(1)) begin
                  r_pop   <= 1'b0;
                  r_err   <= 1'b0;
                  r_code  <= 2'b00;
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_push  <= 1'b0;
               r_pop   <= 1'b0;
            end
         endcase
      end
   end
   assign Tok_Ready   = r_ready;
   assign Stk_Data_In = r_data_in;
   assign Stk_Push    = r_push;
   assign Stk_Pop     = r_pop;
   assign Res_Valid   = r_res_valid;
   assign Res_Data    = r_res_data;
   assign Err         = r_err;
   assign Err_Code    = r_code;
   assign Depth       = r_depth;
endmodule

// File: tb/tb_rpn_stack_master.sv
// tb_rpn_stack_master: directed scenarios against a behavioural 8-entry stack.
module tb_rpn_stack_master;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       tok_valid = 1'b0, tok_is_op = 1'b0;
   logic [3:0] tok_data = 4'd0;
   logic       tok_ready, push, pop, full, empty, res_valid, err;
   logic [3:0] din, dout, res_data, depth;
   logic [1:0] err_code;
   logic [3:0] mem [8];
   logic [3:0] cnt;
   int n_push = 0, n_pop = 0, n_both = 0;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   rpn_stack_master #(.DATA_W(4), .DEPTH(8)) dut (
      .Clk(clk), .RstN(rst_n), .Tok_Valid(tok_valid), .Tok_Is_Op(tok_is_op),
      .Tok_Data(tok_data), .Tok_Ready(tok_ready), .Stk_Data_In(din),
      .Stk_Push(push), .Stk_Pop(pop), .Stk_Data_Out(dout), .Stk_Full(full),
      .Stk_Empty(empty), .Res_Valid(res_valid), .Res_Data(res_data),
      .Err(err), .Err_Code(err_code), .Depth(depth)
   );

   // stack model: popped value appears on dout the cycle after pop
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= 4'd0;
         dout <= 4'd0;
      end else if (push && cnt < 4'd8) begin
         mem[cnt[2:0]] <= din;
         cnt <= cnt + 4'd1;
      end else if (pop && cnt > 4'd0) begin
         dout <= mem[cnt[2:0] - 3'd1];
         cnt  <= cnt - 4'd1;
      end
   end
   assign full  = cnt == 4'd8;
   assign empty = cnt == 4'd0;

   always @(posedge clk) begin
      if (rst_n) begin
         n_push <= n_push + int'(push);
         n_pop  <= n_pop + int'(pop);
         n_both <= n_both + int'(push & pop);
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      tok_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic send(input logic is_op, input logic [3:0] d);
      @(negedge clk);
      tok_valid = 1'b1;
      tok_is_op = is_op;
      tok_data  = d;
      @(negedge clk);
      tok_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 20 && !tok_ready; i++) @(negedge clk);
      checks++;
      if (tok_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s idle timeout: tok_ready=%b required 1", name, tok_ready);
      end
   endtask

   task automatic num(input logic [3:0] v);
      send(1'b0, v);
      wait_idle("num");
   endtask

   task automatic emit_get(output logic [3:0] v, output logic ok);
      send(1'b1, 4'd5);
      ok = 1'b0;
      v  = 4'hx;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (res_valid) begin
            ok = 1'b1;
            v  = res_data;
         end else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks += 9;
      if (tok_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", tok_ready); end
      if (push !== 1'b0)      begin errors++; $display("FAIL rst_push got %b want 0", push); end
      if (pop !== 1'b0)       begin errors++; $display("FAIL rst_pop got %b want 0", pop); end
      if (din !== 4'd0)       begin errors++; $display("FAIL rst_din got %0d want 0", din); end
      if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
      if (res_data !== 4'd0)  begin errors++; $display("FAIL rst_res_data got %0d want 0", res_data); end
      if (err !== 1'b0)       begin errors++; $display("FAIL rst_err got %b want 0", err); end
      if (err_code !== 2'b00) begin errors++; $display("FAIL rst_code got %b want 00", err_code); end
      if (depth !== 4'd0)     begin errors++; $display("FAIL rst_depth got %0d want 0", depth); end
   endtask

   task automatic test_add();
      logic [3:0] v;
      logic ok;
      do_reset();
      send(1'b0, 4'd3);
      checks += 2;
      if (push !== 1'b1 || din !== 4'd3) begin errors++; $display("FAIL add_push3 push=%b din=%0d want 1/3", push, din); end
      if (tok_ready !== 1'b0) begin errors++; $display("FAIL add_ready_c1 got %b want 0", tok_ready); end
      wait_idle("add_p3");
      num(4'd5);
      send(1'b1, 4'd0);
      checks++;
      if (pop !== 1'b1) begin errors++; $display("FAIL add_c1_pop got %b want 1", pop); end
      @(negedge clk);
      checks++;
      if (pop !== 1'b1) begin errors++; $display("FAIL add_c2_pop got %b want 1", pop); end
      @(negedge clk);
      checks++;
      if (pop !== 1'b0 || push !== 1'b0) begin errors++; $display("FAIL add_c3 pop=%b push=%b want 0/0", pop, push); end
      @(negedge clk);
      checks++;
      if (push !== 1'b1 || din !== 4'd8) begin errors++; $display("FAIL add_c4 push=%b din=%0d want 1/8", push, din); end
      @(negedge clk);
      checks++;
      if (tok_ready !== 1'b1 || depth !== 4'd1) begin errors++; $display("FAIL add_c5 ready=%b depth=%0d want 1/1", tok_ready, depth); end
      send(1'b1, 4'd5);
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL emit_c2_valid got %b want 0", res_valid); end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 4'd8 || depth !== 4'd0 || tok_ready !== 1'b1) begin
         errors++;
         $display("FAIL emit_c3 valid=%b data=%0d depth=%0d ready=%b want 1/8/0/1", res_valid, res_data, depth, tok_ready);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || res_data !== 4'd8) begin errors++; $display("FAIL emit_pulse valid=%b data=%0d want 0/8", res_valid, res_data); end
      v = 4'd0;
      ok = 1'b0;
   endtask

   task automatic test_sub();
      logic [3:0] v;
      logic ok;
      do_reset();
      num(4'd2);
      num(4'd5);
      send(1'b1, 4'd1);
      wait_idle("sub");
      emit_get(v, ok);
      checks++;
      if (!ok || v !== 4'd13 || err !== 1'b0) begin errors++; $display("FAIL sub_wrap ok=%b res=%0d err=%b want 1/13/0", ok, v, err); end
   endtask

   task automatic test_logic_ops();
      logic [3:0] v;
      logic ok;
      logic [3:0] opc [3] = '{4'd2, 4'd3, 4'd4};
      logic [3:0] exp [3] = '{4'h8, 4'hE, 4'h6};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         num(4'hC);
         num(4'hA);
         send(1'b1, opc[i]);
         wait_idle("logic");
         emit_get(v, ok);
         checks++;
         if (!ok || v !== exp[i]) begin errors++; $display("FAIL logic_op%0d ok=%b res=%h want %h", opc[i], ok, v, exp[i]); end
         wait_idle("logic_e");
      end
   endtask

   task automatic test_underflow();
      logic [3:0] v;
      logic ok;
      int p0;
      do_reset();
      num(4'd2);
      p0 = n_pop;
      send(1'b1, 4'd1);
      checks += 3;
      if (err !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL uf_code err=%b code=%b want 1/10", err, err_code); end
      if (tok_ready !== 1'b1 || depth !== 4'd1) begin errors++; $display("FAIL uf_state ready=%b depth=%0d want 1/1", tok_ready, depth); end
      if (n_pop != p0) begin errors++; $display("FAIL uf_nopop pops=%0d want %0d", n_pop, p0); end
      emit_get(v, ok);
      checks++;
      if (!ok || v !== 4'd2 || err !== 1'b1) begin errors++; $display("FAIL uf_emit ok=%b res=%0d err=%b want 1/2/1", ok, v, err); end
      wait_idle("uf");
      send(1'b1, 4'd5);
      checks++;
      if (err_code !== 2'b10 || n_pop != p0 + 1) begin errors++; $display("FAIL uf_emit_empty code=%b pops=%0d want 10/%0d", err_code, n_pop, p0 + 1); end
   endtask

   task automatic test_overflow();
      int q0;
      do_reset();
      for (int i = 1; i <= 8; i++) num(4'(i));
      checks++;
      if (depth !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL ov_fill depth=%0d full=%b want 8/1", depth, full); end
      q0 = n_push;
      send(1'b0, 4'd9);
      checks += 2;
      if (err !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL ov_code err=%b code=%b want 1/01", err, err_code); end
      if (push !== 1'b0 || n_push != q0 || depth !== 4'd8 || full !== 1'b1) begin
         errors++;
         $display("FAIL ov_state push=%b pushes=%0d depth=%0d full=%b want 0/%0d/8/1", push, n_push, depth, full, q0);
      end
   endtask

   task automatic test_clear();
      int p0;
      do_reset();
      send(1'b1, 4'd6);
      checks++;
      if (tok_ready !== 1'b1 || pop !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL clr_empty ready=%b pop=%b err=%b want 1/0/0", tok_ready, pop, err); end
      num(4'd1);
      num(4'd2);
      num(4'd3);
      send(1'b1, 4'd7);
      checks++;
      if (err !== 1'b1 || err_code !== 2'b11 || depth !== 4'd3) begin errors++; $display("FAIL illegal err=%b code=%b depth=%0d want 1/11/3", err, err_code, depth); end
      p0 = n_pop;
      send(1'b1, 4'd6);
      checks++;
      if (pop !== 1'b1) begin errors++; $display("FAIL clr_c1_pop got %b want 1", pop); end
      wait_idle("clr");
      checks += 2;
      if (n_pop != p0 + 3) begin errors++; $display("FAIL clr_pops got %0d want 3", n_pop - p0); end
      if (depth !== 4'd0 || err !== 1'b0 || err_code !== 2'b00 || empty !== 1'b1 || pop !== 1'b0) begin
         errors++;
         $display("FAIL clr_final depth=%0d err=%b code=%b empty=%b pop=%b want 0/0/00/1/0", depth, err, err_code, empty, pop);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      num(4'd4);
      num(4'd6);
      send(1'b1, 4'd0);
      @(negedge clk);
      checks++;
      if (pop !== 1'b1) begin errors++; $display("FAIL mr_popa got %b want 1", pop); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (pop !== 1'b0 || push !== 1'b0) begin errors++; $display("FAIL mr_async pop=%b push=%b want 0/0", pop, push); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (tok_ready !== 1'b1 || depth !== 4'd0 || pop !== 1'b0) begin errors++; $display("FAIL mr_after ready=%b depth=%0d pop=%b want 1/0/0", tok_ready, depth, pop); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] v;
      logic ok;
      do_reset();
      num(4'd7);
      num(4'd9);
      num(4'd1);
      send(1'b1, 4'd0);
      wait_idle("b2b1");
      send(1'b1, 4'd1);
      wait_idle("b2b2");
      emit_get(v, ok);
      checks += 2;
      if (!ok || v !== 4'd13) begin errors++; $display("FAIL b2b_res ok=%b res=%0d want 1/13", ok, v); end
      if (n_both != 0) begin errors++; $display("FAIL push_pop_overlap count=%0d want 0", n_both); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic_ops();
      test_underflow();
      test_overflow();
      test_clear();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
